// File: rtl/fifo_read_streamer.sv
// fifo_read_streamer: read-domain drain engine for the dual-clock FIFO.
// Issues read enables against fifo_empty, absorbs the FIFO's one-cycle read
// latency and presents the data as a valid/ready stream through a 2-entry
// skid buffer. It also counts the delivered beats.
// Optional build macro FIFO_STREAM_LAST_EN enables packet framing on m_last
// (a boundary every PKT_LEN beats). Without it, m_last is tied low.
module fifo_read_streamer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned PKT_LEN    = 4
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_ren,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [CNT_WIDTH-1:0]  beat_cnt
);

  localparam int unsigned OCC_W = 2;
  localparam int unsigned SUM_W = 3;

  logic [OCC_W-1:0]      occ;
  logic [OCC_W-1:0]      occ_nxt;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] tail;
  logic [DATA_WIDTH-1:0] head_nxt;
  logic [DATA_WIDTH-1:0] tail_nxt;
  logic                  pop;
  logic                  push;

  assign m_valid = (occ != OCC_W'(0));
  assign m_data  = head;
  assign pop     = m_valid & m_ready;
  assign push    = inflight;

  // Read only while the buffer plus the in-flight beat leaves room after this cycle's pop
  always_comb begin
    fifo_ren = 1'b0;
    if (!rrst && !fifo_empty &&
        ((SUM_W'(occ) + SUM_W'(inflight)) < (SUM_W'(2) + SUM_W'(pop)))) begin
      fifo_ren = 1'b1;
    end
  end

  // Skid buffer next state: head is the oldest beat, tail the second one
  always_comb begin
    occ_nxt  = occ;
    head_nxt = head;
    tail_nxt = tail;
    case ({push, pop})
      2'b10: begin
        occ_nxt = occ + OCC_W'(1);
        if (occ == OCC_W'(0)) begin
          head_nxt = fifo_rdata;
        end else begin
          tail_nxt = fifo_rdata;
        end
      end
      2'b01: begin
        occ_nxt  = occ - OCC_W'(1);
        head_nxt = tail;
      end
      2'b11: begin
        if (occ == OCC_W'(1)) begin
          head_nxt = fifo_rdata;
        end else begin
          head_nxt = tail;
          tail_nxt = fifo_rdata;
        end
      end
      default: begin
      end
    endcase
  end

  // State registers; reset drops buffered and in-flight beats (FIFO cannot rewind)
  always_ff @(posedge rclk) begin
    if (rrst) begin
      occ      <= '0;
      inflight <= 1'b0;
      head     <= '0;
      tail     <= '0;
      beat_cnt <= '0;
    end else begin
      occ      <= occ_nxt;
      inflight <= fifo_ren;
      head     <= head_nxt;
      tail     <= tail_nxt;
      if (pop) begin
        beat_cnt <= beat_cnt + CNT_WIDTH'(1);
      end
    end
  end

  // Sanity checks: buffer overflow is a design error, packet length must be legal
  always_ff @(posedge rclk) begin
    if (rrst) begin
      assert (PKT_LEN >= 1) else $error("fifo_read_streamer: PKT_LEN must be >= 1");
    end else begin
      assert (!(push && !pop && (occ == OCC_W'(2))))
        else $error("fifo_read_streamer: skid buffer overflow");
    end
  end

`ifdef FIFO_STREAM_LAST_EN
  localparam int unsigned PKT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

  logic [PKT_W-1:0] pkt_idx;

  // Position of the head beat within its packet
  always_ff @(posedge rclk) begin
    if (rrst) begin
      pkt_idx <= '0;
    end else if (pop) begin
      if (pkt_idx == PKT_W'(PKT_LEN - 1)) begin
        pkt_idx <= '0;
      end else begin
        pkt_idx <= pkt_idx + PKT_W'(1);
      end
    end
  end

  assign m_last = m_valid & (pkt_idx == PKT_W'(PKT_LEN - 1));
`else
  assign m_last = 1'b0;
`endif

endmodule
